serial_addsub_ctrl: RTL

Bit-serial add/subtract engine that runs a single `fulladder1bit` cell for WIDTH consecutive cycles. It sequences the operand shift registers, carry flop, and bit counter, and exposes a start/busy/done handshake. It is the area-minimal arithmetic option in the logic-circuit datapath, used wherever one adder cell must serve a multi-bit operation.

---
 rtl/logic_pkg.sv | 12 +
 rtl/fulladder1bit.sv | 13 +
 rtl/serial_addsub_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/logic_pkg.sv
// Shared types and defaults for the bit-serial arithmetic datapath.
package logic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/fulladder1bit.sv
// Single-bit full adder cell shared by the serial add/subtract engine.
module fulladder1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract: one full-adder cell iterated WIDTH cycles, LSB first,
// with a start/busy/done handshake and registered result, carry and overflow.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; operands load on the accepting edge
// ST_RUN  | one bit per cycle through the adder cell, cnt = bit index
// ST_DONE | one-cycle done pulse; a new start is accepted here too
module serial_addsub_ctrl
   import logic_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

   state_t state_q, state_d;

   logic [WIDTH-1:0] sh_a, sh_b;
   logic [WIDTH-2:0] sh_r;
   logic [WIDTH-1:0] sum_cat;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             c_msb_in;
   logic             fa_sum, fa_cout;
   logic             load, step, finish;

   fulladder1bit u_fa (
      .a    (sh_a[0]),
      .b    (sh_b[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Holds every sum bit produced so far, newest at the MSB.
   assign sum_cat = {fa_sum, sh_r};

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               load    = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (cnt == CNT_LAST) begin
               state_d = ST_DONE;
               finish  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d == ST_RUN);
         done    <= (state_d == ST_DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a     <= '0;
         sh_b     <= '0;
         sh_r     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         c_msb_in <= 1'b0;
         result   <= '0;
         cout     <= 1'b0;
         ovf      <= 1'b0;
      end else if (load) begin
         sh_a  <= a;
         sh_b  <= sub ? ~b : b;
         carry <= sub;
         cnt   <= '0;
      end else if (step) begin
         sh_a  <= sh_a >> 1;
         sh_b  <= sh_b >> 1;
         sh_r  <= sum_cat[WIDTH-1:1];
         carry <= fa_cout;
         cnt   <= cnt + CW'(1);
         if (cnt == CNT_PENULT) begin
            c_msb_in <= fa_cout;
         end
         // Overflow is carry-into-MSB differing from carry-out-of-MSB.
         if (finish) begin
            result <= sum_cat;
            cout   <= fa_cout;
            ovf    <= fa_cout ^ c_msb_in;
         end
      end
   end

endmodule
